// File: rtl/dom_share_encoder_gf2.sv
// Splits unshared GF(2^2) operands into Boolean shares for the DOM multiplier,
// attaching fresh remask (Z) and blinding (B) randomness from a seeded LFSR.
module dom_share_encoder_gf2 #(
    parameter int          SHARES                   = 2,
    parameter int          FIRST_ORDER_OPTIMIZATION = 1,
    parameter logic [63:0] SEED_DEFAULT             = 64'h0123_4567_89AB_CDEF,
    localparam int BLIND_N =
        (FIRST_ORDER_OPTIMIZATION == 1 && SHARES == 2) ? 1 : SHARES,
    localparam int ZW      = SHARES * (SHARES - 1),
    localparam int SH_W    = 2 * (SHARES - 1),
    localparam int RND_W   = 2 * SH_W + ZW + 2 * BLIND_N
) (
    input  logic                   ClkxCI,
    input  logic                   RstxRI,
    input  logic [63:0]            SeedxDI,
    input  logic                   SeedValidxSI,
    input  logic [1:0]             XxDI,
    input  logic [1:0]             YxDI,
    input  logic                   InValidxSI,
    output logic                   InReadyxSO,
    output logic [2*SHARES-1:0]    _XxDO,
    output logic [2*SHARES-1:0]    _YxDO,
    output logic [ZW-1:0]          _ZxDO,
    output logic [2*BLIND_N-1:0]   _BxDO,
    output logic                   OutValidxSO,
    input  logic                   OutReadyxSI
);

    typedef enum logic {
        UNSEEDED,
        RUN
    } state_t;

    state_t stateQ, stateD;

    logic [63:0]          lfsrQ;
    logic [63:0]          lfsrAdv;
    logic [63:0]          seedFix;
    logic [RND_W-1:0]     rnd;
    logic [2*SHARES-1:0]  xSh, ySh;
    logic [1:0]           xAcc, yAcc;
    logic [2*SHARES-1:0]  xQ, yQ;
    logic [ZW-1:0]        zQ;
    logic [2*BLIND_N-1:0] bQ;
    logic                 validQ;
    logic                 inReady;
    logic                 xfer;

    always_comb begin
        stateD  = stateQ;
        inReady = 1'b0;
        unique case (stateQ)
            UNSEEDED: begin
                if (SeedValidxSI) stateD = RUN;
            end
            RUN: begin
                inReady = !validQ || OutReadyxSI;
            end
            default: stateD = UNSEEDED;
        endcase
    end

    assign xfer    = InValidxSI && inReady;
    assign seedFix = (SeedxDI == 64'd0) ? SEED_DEFAULT : SeedxDI;

    // RND_W Fibonacci steps unrolled; bit k is the k-th feedback bit produced
    always_comb begin
        lfsrAdv = lfsrQ;
        rnd     = '0;
        for (int k = 0; k < RND_W; k++) begin
            rnd[k]  = lfsrAdv[63] ^ lfsrAdv[62] ^ lfsrAdv[60] ^ lfsrAdv[59];
            lfsrAdv = {lfsrAdv[62:0], rnd[k]};
        end
    end

    always_comb begin
        xSh  = '0;
        ySh  = '0;
        xAcc = XxDI;
        yAcc = YxDI;
        for (int i = 1; i < SHARES; i++) begin
            xSh[2*i +: 2] = rnd[2*(i-1) +: 2];
            ySh[2*i +: 2] = rnd[SH_W + 2*(i-1) +: 2];
            xAcc          = xAcc ^ rnd[2*(i-1) +: 2];
            yAcc          = yAcc ^ rnd[SH_W + 2*(i-1) +: 2];
        end
        xSh[1:0] = xAcc;
        ySh[1:0] = yAcc;
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            stateQ <= UNSEEDED;
        end else begin
            stateQ <= stateD;
        end
    end

    // Seed load wins over the advance of a same-cycle transfer
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            lfsrQ <= SEED_DEFAULT;
        end else if (SeedValidxSI) begin
            lfsrQ <= seedFix;
        end else if (xfer) begin
            lfsrQ <= lfsrAdv;
        end
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            validQ <= 1'b0;
            xQ     <= '0;
            yQ     <= '0;
            zQ     <= '0;
            bQ     <= '0;
        end else if (xfer) begin
            validQ <= 1'b1;
            xQ     <= xSh;
            yQ     <= ySh;
            zQ     <= rnd[2*SH_W +: ZW];
            bQ     <= rnd[2*SH_W + ZW +: 2*BLIND_N];
        end else if (validQ && OutReadyxSI) begin
            validQ <= 1'b0;
        end
    end

    assign InReadyxSO  = inReady;
    assign OutValidxSO = validQ;
    assign _XxDO       = xQ;
    assign _YxDO       = yQ;
    assign _ZxDO       = zQ;
    assign _BxDO       = bQ;

endmodule

// File: tb/tb_dom_share_encoder_gf2.sv
// Scoreboard bench: three encoders (2, 3, 4 shares) share one stimulus stream
// and are checked against an LFSR-bit-stream reference model.
module tb_dom_share_encoder_gf2;

    localparam logic [63:0] DEF = 64'h0123_4567_89AB_CDEF;

    typedef struct packed {
        logic [7:0]  xs;
        logic [7:0]  ys;
        logic [11:0] z;
        logic [7:0]  b;
        logic [1:0]  x;
        logic [1:0]  y;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] seed = '0;
    logic        seedV = 1'b0;
    logic [1:0]  xi = '0, yi = '0;
    logic        iv = 1'b0;
    logic        ordy = 1'b0;

    logic        rdy2, rdy3, rdy4, v2, v3, v4;
    logic [3:0]  x2, y2;
    logic [1:0]  z2, b2;
    logic [5:0]  x3, y3, z3, b3;
    logic [7:0]  x4, y4, b4;
    logic [11:0] z4;

    int nTests = 0;
    int nFail  = 0;

    exp_t        q2[$], q3[$], q4[$];
    logic [63:0] st2, st3, st4;
    logic        seeded, expValid;

    always #5 clk = ~clk;

    dom_share_encoder_gf2 #(.SHARES(2), .FIRST_ORDER_OPTIMIZATION(1)) dut2 (
        .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed), .SeedValidxSI(seedV),
        .XxDI(xi), .YxDI(yi), .InValidxSI(iv), .InReadyxSO(rdy2),
        ._XxDO(x2), ._YxDO(y2), ._ZxDO(z2), ._BxDO(b2),
        .OutValidxSO(v2), .OutReadyxSI(ordy));

    dom_share_encoder_gf2 #(.SHARES(3), .FIRST_ORDER_OPTIMIZATION(0)) dut3 (
        .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed), .SeedValidxSI(seedV),
        .XxDI(xi), .YxDI(yi), .InValidxSI(iv), .InReadyxSO(rdy3),
        ._XxDO(x3), ._YxDO(y3), ._ZxDO(z3), ._BxDO(b3),
        .OutValidxSO(v3), .OutReadyxSI(ordy));

    dom_share_encoder_gf2 #(.SHARES(4), .FIRST_ORDER_OPTIMIZATION(0)) dut4 (
        .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed), .SeedValidxSI(seedV),
        .XxDI(xi), .YxDI(yi), .InValidxSI(iv), .InReadyxSO(rdy4),
        ._XxDO(x4), ._YxDO(y4), ._ZxDO(z4), ._BxDO(b4),
        .OutValidxSO(v4), .OutReadyxSI(ordy));

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: draw the bit stream, then hand bits out in order
    task automatic gen(input int s, input int bn, input logic [1:0] x,
                       input logic [1:0] y, input logic [63:0] stIn,
                       output exp_t e, output logic [63:0] stOut);
        bit r[$];
        bit nb;
        int pos;
        int rw;
        logic [63:0] st;
        logic [1:0] acc;
        e   = '0;
        st  = stIn;
        rw  = 4 * (s - 1) + s * (s - 1) + 2 * bn;
        for (int k = 0; k < rw; k++) begin
            nb = st[63] ^ st[62] ^ st[60] ^ st[59];
            st = {st[62:0], nb};
            r.push_back(nb);
        end
        pos = 0;
        acc = x;
        for (int i = 1; i < s; i++) begin
            e.xs[2*i]   = r[pos];
            e.xs[2*i+1] = r[pos+1];
            acc = acc ^ {r[pos+1], r[pos]};
            pos += 2;
        end
        e.xs[1:0] = acc;
        acc = y;
        for (int i = 1; i < s; i++) begin
            e.ys[2*i]   = r[pos];
            e.ys[2*i+1] = r[pos+1];
            acc = acc ^ {r[pos+1], r[pos]};
            pos += 2;
        end
        e.ys[1:0] = acc;
        for (int j = 0; j < s * (s - 1); j++) e.z[j] = r[pos++];
        for (int j = 0; j < 2 * bn; j++) e.b[j] = r[pos++];
        e.x   = x;
        e.y   = y;
        stOut = st;
    endtask

    task automatic cmp(input string nm, input int s, input exp_t e,
                       input logic [7:0] ax, input logic [7:0] ay,
                       input logic [11:0] az, input logic [7:0] ab);
        logic [1:0] rx, ry;
        rx = '0;
        ry = '0;
        for (int i = 0; i < s; i++) begin
            rx = rx ^ ax[2*i +: 2];
            ry = ry ^ ay[2*i +: 2];
        end
        chk({nm, ".xrecomb"}, 64'(rx), 64'(e.x));
        chk({nm, ".yrecomb"}, 64'(ry), 64'(e.y));
        chk({nm, ".xshares"}, 64'(ax), 64'(e.xs));
        chk({nm, ".yshares"}, 64'(ay), 64'(e.ys));
        chk({nm, ".z"}, 64'(az), 64'(e.z));
        chk({nm, ".b"}, 64'(ab), 64'(e.b));
    endtask

    task automatic emptyFail(input string nm);
        nTests++;
        nFail++;
        $display("FAIL %s: output valid but scoreboard empty at %0t", nm, $time);
    endtask

    // Monitor: compare the head beat whenever valid, retire it on handshake
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (v2) begin
                    if (q2.size() == 0) emptyFail("s2");
                    else begin
                        cmp("s2", 2, q2[0], {4'b0, x2}, {4'b0, y2},
                            {10'b0, z2}, {6'b0, b2});
                        if (ordy) void'(q2.pop_front());
                    end
                end
                if (v3) begin
                    if (q3.size() == 0) emptyFail("s3");
                    else begin
                        cmp("s3", 3, q3[0], {2'b0, x3}, {2'b0, y3},
                            {6'b0, z3}, {2'b0, b3});
                        if (ordy) void'(q3.pop_front());
                    end
                end
                if (v4) begin
                    if (q4.size() == 0) emptyFail("s4");
                    else begin
                        cmp("s4", 4, q4[0], x4, y4, z4, b4);
                        if (ordy) void'(q4.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input logic iv_, input logic [1:0] x_,
                        input logic [1:0] y_, input logic sv_,
                        input logic [63:0] sd_, input logic ordy_);
        logic expRdy;
        logic xfer;
        exp_t e;
        @(negedge clk);
        iv    = iv_;
        xi    = x_;
        yi    = y_;
        seedV = sv_;
        seed  = sd_;
        ordy  = ordy_;
        #1;
        expRdy = seeded && (!expValid || ordy_);
        chk("inready2", 64'(rdy2), 64'(expRdy));
        chk("inready3", 64'(rdy3), 64'(expRdy));
        chk("inready4", 64'(rdy4), 64'(expRdy));
        chk("outvalid2", 64'(v2), 64'(expValid));
        chk("outvalid3", 64'(v3), 64'(expValid));
        chk("outvalid4", 64'(v4), 64'(expValid));
        xfer = iv_ && expRdy;
        if (xfer) begin
            gen(2, 1, x_, y_, st2, e, st2);
            q2.push_back(e);
            gen(3, 3, x_, y_, st3, e, st3);
            q3.push_back(e);
            gen(4, 4, x_, y_, st4, e, st4);
            q4.push_back(e);
        end
        if (sv_) begin
            st2 = (sd_ == 64'd0) ? DEF : sd_;
            st3 = st2;
            st4 = st2;
            seeded = 1'b1;
        end
        expValid = xfer || (expValid && !ordy_);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst   = 1'b1;
        iv    = 1'b0;
        seedV = 1'b0;
        #1;
        seeded   = 1'b0;
        expValid = 1'b0;
        st2 = DEF;
        st3 = DEF;
        st4 = DEF;
        q2.delete();
        q3.delete();
        q4.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.valid", 64'({v2, v3, v4}), 64'd0);
        chk("rst.ready", 64'({rdy2, rdy3, rdy4}), 64'd0);
        chk("rst.data2", 64'({x2, y2, z2, b2}), 64'd0);
        chk("rst.data3", 64'({x3, y3, z3, b3}), 64'd0);
        chk("rst.data4x", 64'({x4, y4, b4}), 64'd0);
        chk("rst.data4z", 64'(z4), 64'd0);
    endtask

    initial begin
        seeded   = 1'b0;
        expValid = 1'b0;
        st2 = DEF;
        st3 = DEF;
        st4 = DEF;
        doReset();

        // no seed: never ready, never valid
        for (int i = 0; i < 10; i++) step(1, 2'b11, 2'b10, 0, 0, 1);

        // seed 1, single known beat
        step(0, 0, 0, 1, 64'h1, 1);
        step(1, 2'b10, 2'b01, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // stall five cycles with a pending input, then release
        step(1, 2'b01, 2'b11, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 2'b10, 2'b10, 0, 0, 0);
        step(1, 2'b11, 2'b00, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // zero seed maps to the default seed
        doReset();
        step(0, 0, 0, 1, 64'h0, 1);
        step(1, 2'b01, 2'b10, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // seed load coinciding with a transfer
        step(1, 2'b11, 2'b11, 1, 64'hDEAD_BEEF_0000_0001, 1);
        step(1, 2'b00, 2'b01, 0, 0, 1);

        // 16 back-to-back beats
        for (int i = 0; i < 16; i++)
            step(1, 2'($urandom), 2'($urandom), 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // reset mid-stall, then reseed and rerun the same sequence
        step(0, 0, 0, 1, 64'h5A5A_0F0F_1234_8765, 1);
        step(1, 2'b10, 2'b01, 0, 0, 0);
        step(1, 2'b01, 2'b01, 0, 0, 0);
        doReset();
        step(0, 0, 0, 1, 64'h5A5A_0F0F_1234_8765, 1);
        step(1, 2'b10, 2'b01, 0, 0, 1);
        step(1, 2'b01, 2'b01, 0, 0, 1);

        // randomized traffic with occasional reseeds
        for (int i = 0; i < 400; i++) begin
            logic [63:0] sd;
            sd = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 7) == 0) sd = 64'd0;
            step($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom),
                 $urandom_range(0, 39) == 0, sd, $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        chk("drain.q2", 64'(q2.size()), 64'd0);
        chk("drain.q3", 64'(q3.size()), 64'd0);
        chk("drain.q4", 64'(q4.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
